// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: issues source reads, tracks outstanding destination
// writes, forwards writeback data and registers operands for execute.
//
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   issue_valid/issue_ready         decode handshake
//   rs, rt, use_rs, use_rt          source registers and use flags
//   rd, rd_write                    destination register and write flag
//   rf_read1/2, rf_data1/2          register file read port
//   wb_valid, wb_reg, wb_data       writeback bus (same strobe as rf write)
//   op_valid/op_ready               operand stage handshake to execute
//   op_a, op_b, op_rd, op_rd_write  registered operand stage fields
//   stall_count                     saturating count of stalled issue cycles
module operand_fetch_scoreboard #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic              use_rs,
   input  logic              use_rt,
   input  logic [4:0]        rd,
   input  logic              rd_write,
   output logic [4:0]        rf_read1,
   output logic [4:0]        rf_read2,
   input  logic [DATA_W-1:0] rf_data1,
   input  logic [DATA_W-1:0] rf_data2,
   input  logic              wb_valid,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [4:0]        op_rd,
   output logic              op_rd_write,
   output logic [CNT_W-1:0]  stall_count
);

   logic [31:0]       r_pending;
   logic              r_op_valid;
   logic [DATA_W-1:0] r_op_a;
   logic [DATA_W-1:0] r_op_b;
   logic [4:0]        r_op_rd;
   logic              r_op_rd_write;
   logic [CNT_W-1:0]  r_stall;

   logic              w_fwd_rs;
   logic              w_fwd_rt;
   logic              w_fwd_rd;
   logic              w_haz_rs;
   logic              w_haz_rt;
   logic              w_waw;
   logic              w_space;
   logic              w_ready;
   logic              w_accept;
   logic              w_set;
   logic [DATA_W-1:0] w_sel_a;
   logic [DATA_W-1:0] w_sel_b;
   logic [31:0]       w_pend_nxt;

   assign rf_read1 = rs;
   assign rf_read2 = rt;

   // A writeback landing this cycle resolves the hazard it would clear.
   assign w_fwd_rs = wb_valid && (wb_reg == rs) && (rs != 5'd0);
   assign w_fwd_rt = wb_valid && (wb_reg == rt) && (rt != 5'd0);
   assign w_fwd_rd = wb_valid && (wb_reg == rd);

   assign w_haz_rs = use_rs && (rs != 5'd0) && r_pending[rs] && !w_fwd_rs;
   assign w_haz_rt = use_rt && (rt != 5'd0) && r_pending[rt] && !w_fwd_rt;
   assign w_waw    = rd_write && (rd != 5'd0) && r_pending[rd] && !w_fwd_rd;

   assign w_space  = !r_op_valid || op_ready;
   assign w_ready  = w_space && !w_haz_rs && !w_haz_rt && !w_waw;
   assign w_accept = issue_valid && w_ready;
   assign w_set    = w_accept && rd_write && (rd != 5'd0);

   assign issue_ready = w_ready;

   always_comb begin
      w_sel_a = rf_data1;
      if (rs == 5'd0) begin
         w_sel_a = '0;
      end else if (w_fwd_rs) begin
         w_sel_a = wb_data;
      end
   end

   always_comb begin
      w_sel_b = rf_data2;
      if (rt == 5'd0) begin
         w_sel_b = '0;
      end else if (w_fwd_rt) begin
         w_sel_b = wb_data;
      end
   end

   // Clear first, then set, so a same-register set wins.
   always_comb begin
      w_pend_nxt = r_pending;
      if (wb_valid) begin
         w_pend_nxt[wb_reg] = 1'b0;
      end
      if (w_set) begin
         w_pend_nxt[rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pend_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_op_valid    <= 1'b0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_op_rd       <= '0;
         r_op_rd_write <= 1'b0;
      end else if (w_accept) begin
         r_op_valid    <= 1'b1;
         r_op_a        <= w_sel_a;
         r_op_b        <= w_sel_b;
         r_op_rd       <= rd;
         r_op_rd_write <= rd_write;
      end else if (op_ready) begin
         r_op_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stall <= '0;
      end else if (issue_valid && !w_ready && (r_stall != {CNT_W{1'b1}})) begin
         r_stall <= r_stall + 1'b1;
      end
   end

   assign op_valid    = r_op_valid;
   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign op_rd       = r_op_rd;
   assign op_rd_write = r_op_rd_write;
   assign stall_count = r_stall;

endmodule
